// File: rtl/array_pack_arbiter.sv
// array_pack_arbiter
// Collects two signed elements from two requesters under a round-robin grant
// and presents them as one packed two-element array with source tags.
module array_pack_arbiter #(
   parameter int DATA_W      = 32,
   parameter bit START_GRANT = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic signed [DATA_W-1:0]   req0_in,
   input  logic                       req0_in_sync,
   output logic                       req0_in_notify,
   input  logic signed [DATA_W-1:0]   req1_in,
   input  logic                       req1_in_sync,
   output logic                       req1_in_notify,
   output logic [2*DATA_W-1:0]        b_out,
   input  logic                       b_out_sync,
   output logic                       b_out_notify,
   output logic [1:0]                 b_out_src,
   output logic [15:0]                pack_count
);

   typedef enum logic [1:0] {FILL0, FILL1, SEND} state_t;

   state_t                     state_q, state_d;
   logic                       g_q, g_d;
   logic                       n0_q, n0_d;
   logic                       n1_q, n1_d;
   logic                       bnot_q, bnot_d;
   logic [2*DATA_W-1:0]        bout_q, bout_d;
   logic [1:0]                 src_q, src_d;
   logic [15:0]                cnt_q, cnt_d;
   logic signed [DATA_W-1:0]   elem0_q, elem0_d;

   logic                       xfer;
   logic signed [DATA_W-1:0]   xdata;

   // Transfer only through the channel whose registered notify is high;
   // the other requester's sync and data are never looked at.
   assign xfer  = (n0_q & req0_in_sync) | (n1_q & req1_in_sync);
   assign xdata = g_q ? req1_in : req0_in;

   // Next-state logic: grant toggles every fill cycle, frozen while sending.
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      bnot_d  = bnot_q;
      bout_d  = bout_q;
      src_d   = src_q;
      cnt_d   = cnt_q;
      elem0_d = elem0_q;
      case (state_q)
         FILL0: begin
            g_d = ~g_q;
            if (xfer) begin
               elem0_d  = xdata;
               src_d[0] = g_q;
               state_d  = FILL1;
            end
         end
         FILL1: begin
            g_d = ~g_q;
            if (xfer) begin
               bout_d   = {xdata, elem0_q};
               src_d[1] = g_q;
               bnot_d   = 1'b1;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (b_out_sync) begin
               bnot_d  = 1'b0;
               cnt_d   = cnt_q + 16'd1;
               state_d = FILL0;
            end
         end
         default: state_d = FILL0;
      endcase
      // Notifies are registered, so they follow the next grant and state.
      n0_d = (state_d != SEND) & ~g_d;
      n1_d = (state_d != SEND) &  g_d;
   end

   // State and output registers; reset drops any partial or pending array.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL0;
         g_q     <= START_GRANT;
         n0_q    <= ~START_GRANT;
         n1_q    <= START_GRANT;
         bnot_q  <= 1'b0;
         bout_q  <= '0;
         src_q   <= '0;
         cnt_q   <= '0;
         elem0_q <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         n0_q    <= n0_d;
         n1_q    <= n1_d;
         bnot_q  <= bnot_d;
         bout_q  <= bout_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
         elem0_q <= elem0_d;
      end
   end

   assign req0_in_notify = n0_q;
   assign req1_in_notify = n1_q;
   assign b_out_notify   = bnot_q;
   assign b_out          = bout_q;
   assign b_out_src      = src_q;
   assign pack_count     = cnt_q;

endmodule

// File: tb/tb_array_pack_arbiter.sv
// tb_array_pack_arbiter
// Directed vectors with hand-computed expectations for array_pack_arbiter.
module tb_array_pack_arbiter;

   localparam int DATA_W = 32;

   logic                      clk = 1'b0;
   logic                      rst;
   logic signed [DATA_W-1:0]  req0_in, req1_in;
   logic                      req0_in_sync, req1_in_sync;
   logic                      req0_in_notify, req1_in_notify;
   logic [2*DATA_W-1:0]       b_out;
   logic                      b_out_sync, b_out_notify;
   logic [1:0]                b_out_src;
   logic [15:0]               pack_count;

   int errs   = 0;
   int checks = 0;

   array_pack_arbiter #(.DATA_W(DATA_W), .START_GRANT(1'b0)) dut (
      .clk            (clk),
      .rst            (rst),
      .req0_in        (req0_in),
      .req0_in_sync   (req0_in_sync),
      .req0_in_notify (req0_in_notify),
      .req1_in        (req1_in),
      .req1_in_sync   (req1_in_sync),
      .req1_in_notify (req1_in_notify),
      .b_out          (b_out),
      .b_out_sync     (b_out_sync),
      .b_out_notify   (b_out_notify),
      .b_out_src      (b_out_src),
      .pack_count     (pack_count)
   );

   always #5 clk = ~clk;

   // Count a comparison and report it when observed differs from expected.
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_n0"},   req0_in_notify, 1'b1);
      chk({tag, "_n1"},   req1_in_notify, 1'b0);
      chk({tag, "_bnot"}, b_out_notify,   1'b0);
      chk({tag, "_bout"}, b_out,          64'h0);
      chk({tag, "_src"},  b_out_src,      2'b00);
      chk({tag, "_cnt"},  pack_count,     16'h0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      chk_reset("rst");
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req0_in = '0; req1_in = '0;
      req0_in_sync = 1'b0; req1_in_sync = 1'b0;
      b_out_sync = 1'b0;
      #1;
      do_reset();

      // Single requester supplies both elements; req1 idle.
      req0_in_sync = 1'b1; req0_in = 32'sd5;
      cyc();
      chk("t1_n0_after_cap0", req0_in_notify, 1'b0);
      chk("t1_n1_after_cap0", req1_in_notify, 1'b1);
      req0_in = 32'sd7;
      cyc();
      chk("t1_n0_regrant", req0_in_notify, 1'b1);
      chk("t1_bnot_not_yet", b_out_notify, 1'b0);
      cyc();
      chk("t1_bout", b_out, {32'd7, 32'd5});
      chk("t1_src", b_out_src, 2'b00);
      chk("t1_bnot", b_out_notify, 1'b1);
      chk("t1_cnt_before", pack_count, 16'd0);
      chk("t1_n0_send", req0_in_notify, 1'b0);
      req0_in_sync = 1'b0; b_out_sync = 1'b1;
      cyc();
      b_out_sync = 1'b0;
      chk("t1_cnt_after", pack_count, 16'd1);
      chk("t1_bnot_after", b_out_notify, 1'b0);
      chk("t1_n1_after", req1_in_notify, 1'b1);
      chk("t1_n0_after", req0_in_notify, 1'b0);
      chk("t1_bout_held", b_out, {32'd7, 32'd5});

      // Both requesters offer continuously; then SEND stall for 10 cycles.
      do_reset();
      req0_in = 32'sh0A; req1_in = 32'sh0B;
      req0_in_sync = 1'b1; req1_in_sync = 1'b1;
      cyc();
      cyc();
      chk("t2_bout", b_out, {32'h0B, 32'h0A});
      chk("t2_src", b_out_src, 2'b10);
      chk("t2_bnot", b_out_notify, 1'b1);
      req0_in = 32'shDEAD; req1_in = 32'shDEAD;
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("t3_bout_stall", b_out, {32'h0B, 32'h0A});
         chk("t3_src_stall", b_out_src, 2'b10);
         chk("t3_bnot_stall", b_out_notify, 1'b1);
         chk("t3_n0_stall", req0_in_notify, 1'b0);
         chk("t3_n1_stall", req1_in_notify, 1'b0);
      end
      req0_in = 32'sh1; req1_in = 32'sh2;
      b_out_sync = 1'b1;
      cyc();
      b_out_sync = 1'b0;
      chk("t2_cnt1", pack_count, 16'd1);
      chk("t2_n0_restart", req0_in_notify, 1'b1);
      cyc();
      chk("t2_n1_fill1", req1_in_notify, 1'b1);
      cyc();
      chk("t2_bout2", b_out, {32'h2, 32'h1});
      chk("t2_src2", b_out_src, 2'b10);
      req0_in_sync = 1'b0; req1_in_sync = 1'b0;
      b_out_sync = 1'b1;
      cyc();
      b_out_sync = 1'b0;
      chk("t2_cnt2", pack_count, 16'd2);

      // Non-granted requester offers 0xDEAD; captured only once granted.
      req1_in = 32'shDEAD; req1_in_sync = 1'b1;
      cyc();
      chk("t4_n1_granted", req1_in_notify, 1'b1);
      chk("t4_no_send", b_out_notify, 1'b0);
      cyc();
      req1_in_sync = 1'b0;
      req0_in = 32'sh55; req0_in_sync = 1'b1;
      cyc();
      req0_in_sync = 1'b0;
      chk("t4_bout", b_out, {32'h55, 32'hDEAD});
      chk("t4_src", b_out_src, 2'b01);
      b_out_sync = 1'b1;
      cyc();
      b_out_sync = 1'b0;
      chk("t4_cnt3", pack_count, 16'd3);

      // Reset in FILL1 discards element 0.
      chk("t5_n1_grant", req1_in_notify, 1'b1);
      req1_in = 32'sh99; req1_in_sync = 1'b1;
      cyc();
      req1_in_sync = 1'b0;
      rst = 1'b1;
      #1;
      chk_reset("t5_async");
      cyc();
      rst = 1'b0;
      req0_in = 32'sh11; req1_in = 32'sh22;
      req0_in_sync = 1'b1; req1_in_sync = 1'b1;
      cyc();
      cyc();
      chk("t5_bout", b_out, {32'h22, 32'h11});
      chk("t5_src", b_out_src, 2'b10);
      b_out_sync = 1'b1;
      cyc();
      chk("t5_cnt1", pack_count, 16'd1);

      // Back-to-back delivery: one array every three cycles.
      do_reset();
      b_out_sync = 1'b1;
      for (int i = 0; i < 30; i++) cyc();
      chk("t6_cnt10", pack_count, 16'd10);
      chk("t6_n0_end", req0_in_notify, 1'b1);
      chk("t6_bnot_end", b_out_notify, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
